// File: rtl/wavegen_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_cmd_ctrl
// Description : Command sequencer between the SPI byte receiver and the
//               waveform generator. Parses 1- to 3-byte command frames,
//               applies complete frames atomically to the generator
//               configuration, aborts stalled frames and counts errors.
// Revision    : 1.0 - initial release
// ============================================================================
module wavegen_cmd_ctrl #(
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter logic [15:0] DEFAULT_INC    = 16'h0100,
    parameter logic [7:0]  DEFAULT_AMP    = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_valid,
    output logic [1:0]  wave_sel,
    output logic [15:0] phase_inc,
    output logic [7:0]  amplitude,
    output logic        gen_enable,
    output logic        cfg_update,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    // Timer only needs to reach TIMEOUT_CYCLES-1.
    localparam int             TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_WAVE = 4'h1;
    localparam logic [3:0] OP_FREQ = 4'h2;
    localparam logic [3:0] OP_AMP  = 4'h3;
    localparam logic [3:0] OP_ENA  = 4'h4;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    bytes_left_q, bytes_left_d;
    logic          is_freq_q, is_freq_d;     // 1: SET_FREQ frame, 0: SET_AMP frame
    logic [7:0]    shadow_q, shadow_d;       // holds the frequency MSB until the LSB arrives
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    wave_sel_q, wave_sel_d;
    logic [15:0]   phase_inc_q, phase_inc_d;
    logic [7:0]    amplitude_q, amplitude_d;
    logic          gen_enable_q, gen_enable_d;
    logic          cfg_update_q, cfg_update_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          busy_q, busy_d;
    logic          err_event;

    logic [3:0] op;
    logic [3:0] arg;
    assign op  = cmd_byte[7:4];
    assign arg = cmd_byte[3:0];

    // Next-state decode: opcode parsing, payload collection and timeout abort.
    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        is_freq_d    = is_freq_q;
        shadow_d     = shadow_q;
        timer_d      = timer_q;
        wave_sel_d   = wave_sel_q;
        phase_inc_d  = phase_inc_q;
        amplitude_d  = amplitude_q;
        gen_enable_d = gen_enable_q;
        cfg_update_d = 1'b0;
        err_event    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_NOP: ;
                        OP_WAVE: begin
                            wave_sel_d   = arg[1:0];
                            cfg_update_d = 1'b1;
                        end
                        OP_FREQ: begin
                            state_d      = S_PAYLOAD;
                            bytes_left_d = 2'd2;
                            is_freq_d    = 1'b1;
                            timer_d      = '0;
                        end
                        OP_AMP: begin
                            state_d      = S_PAYLOAD;
                            bytes_left_d = 2'd1;
                            is_freq_d    = 1'b0;
                            timer_d      = '0;
                        end
                        OP_ENA: begin
                            gen_enable_d = arg[0];
                            cfg_update_d = 1'b1;
                        end
                        default: err_event = 1'b1;
                    endcase
                end
            end
            S_PAYLOAD: begin
                // A byte arriving in the expiry cycle takes priority over the abort.
                if (cmd_valid) begin
                    timer_d = '0;
                    if (bytes_left_q == 2'd2) begin
                        shadow_d     = cmd_byte;
                        bytes_left_d = 2'd1;
                    end else begin
                        if (is_freq_q) begin
                            phase_inc_d = {shadow_q, cmd_byte};
                        end else begin
                            amplitude_d = cmd_byte;
                        end
                        cfg_update_d = 1'b1;
                        bytes_left_d = 2'd0;
                        state_d      = S_IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_event    = 1'b1;
                    timer_d      = '0;
                    bytes_left_d = 2'd0;
                    state_d      = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame_err_d = err_event;
        err_count_d = (err_event && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
        busy_d      = (state_d == S_PAYLOAD);
    end

    // State and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bytes_left_q <= 2'd0;
            is_freq_q    <= 1'b0;
            shadow_q     <= 8'h00;
            timer_q      <= '0;
            wave_sel_q   <= 2'd0;
            phase_inc_q  <= DEFAULT_INC;
            amplitude_q  <= DEFAULT_AMP;
            gen_enable_q <= 1'b0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            is_freq_q    <= is_freq_d;
            shadow_q     <= shadow_d;
            timer_q      <= timer_d;
            wave_sel_q   <= wave_sel_d;
            phase_inc_q  <= phase_inc_d;
            amplitude_q  <= amplitude_d;
            gen_enable_q <= gen_enable_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
            busy_q       <= busy_d;
        end
    end

    assign wave_sel   = wave_sel_q;
    assign phase_inc  = phase_inc_q;
    assign amplitude  = amplitude_q;
    assign gen_enable = gen_enable_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wavegen_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wavegen_cmd_ctrl
// Description : Directed self-checking bench for wavegen_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wavegen_cmd_ctrl;

    localparam int T = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic [1:0]  wave_sel;
    logic [15:0] phase_inc;
    logic [7:0]  amplitude;
    logic        gen_enable;
    logic        cfg_update;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    int vectors;
    int miscompares;

    wavegen_cmd_ctrl #(
        .TIMEOUT_CYCLES (T),
        .DEFAULT_INC    (16'h0100),
        .DEFAULT_AMP    (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .wave_sel   (wave_sel),
        .phase_inc  (phase_inc),
        .amplitude  (amplitude),
        .gen_enable (gen_enable),
        .cfg_update (cfg_update),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe one byte; returns #1 after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({wave_sel, phase_inc, amplitude, gen_enable, cfg_update, frame_err, err_count, busy}
            !== {2'd0, 16'h0100, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got ws=%0d inc=%h amp=%h en=%b upd=%b err=%b cnt=%h busy=%b, want ws=0 inc=0100 amp=ff en=0 upd=0 err=0 cnt=00 busy=0",
                     wave_sel, phase_inc, amplitude, gen_enable, cfg_update, frame_err, err_count, busy);
        end
    endtask

    task automatic test_set_wave();
        send_byte(8'h13);
        vectors++;
        if ({wave_sel, cfg_update, busy} !== {2'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL set_wave: got ws=%0d upd=%b busy=%b, want ws=3 upd=1 busy=0", wave_sel, cfg_update, busy);
        end
        idle(1);
        vectors++;
        if ({wave_sel, cfg_update, busy} !== {2'd3, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL set_wave_pulse: got ws=%0d upd=%b busy=%b, want ws=3 upd=0 busy=0", wave_sel, cfg_update, busy);
        end
        // NOP: nothing changes, no update pulse
        send_byte(8'h0F);
        vectors++;
        if ({wave_sel, cfg_update, frame_err} !== {2'd3, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL nop: got ws=%0d upd=%b err=%b, want ws=3 upd=0 err=0", wave_sel, cfg_update, frame_err);
        end
        // Same value rewritten still pulses cfg_update
        send_byte(8'h17);
        vectors++;
        if ({wave_sel, cfg_update} !== {2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL set_wave_same: got ws=%0d upd=%b, want ws=3 upd=1", wave_sel, cfg_update);
        end
    endtask

    task automatic test_set_freq();
        int upd_seen;
        upd_seen = 0;
        send_byte(8'h20);
        vectors++;
        if ({busy, cfg_update, phase_inc} !== {1'b1, 1'b0, 16'h0100}) begin
            miscompares++;
            $display("FAIL freq_opcode: got busy=%b upd=%b inc=%h, want busy=1 upd=0 inc=0100", busy, cfg_update, phase_inc);
        end
        idle(10);
        send_byte(8'h12);
        vectors++;
        if ({busy, cfg_update, phase_inc} !== {1'b1, 1'b0, 16'h0100}) begin
            miscompares++;
            $display("FAIL freq_msb: got busy=%b upd=%b inc=%h, want busy=1 upd=0 inc=0100", busy, cfg_update, phase_inc);
        end
        idle(10);
        vectors++;
        if (phase_inc !== 16'h0100) begin
            miscompares++;
            $display("FAIL freq_hold: got inc=%h, want 0100", phase_inc);
        end
        send_byte(8'h34);
        vectors++;
        if ({busy, cfg_update, phase_inc} !== {1'b0, 1'b1, 16'h1234}) begin
            miscompares++;
            $display("FAIL freq_apply: got busy=%b upd=%b inc=%h, want busy=0 upd=1 inc=1234", busy, cfg_update, phase_inc);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (cfg_update) upd_seen++;
        end
        vectors++;
        if (upd_seen != 0 || phase_inc !== 16'h1234) begin
            miscompares++;
            $display("FAIL freq_single_pulse: got extra_upd=%0d inc=%h, want 0 and 1234", upd_seen, phase_inc);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h30);
        idle(T - 1);
        vectors++;
        if ({busy, frame_err} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_early: got busy=%b err=%b, want busy=1 err=0", busy, frame_err);
        end
        idle(1);
        vectors++;
        if ({busy, frame_err, amplitude, cfg_update, err_count} !== {1'b0, 1'b1, 8'hFF, 1'b0, 8'h01}) begin
            miscompares++;
            $display("FAIL timeout_abort: got busy=%b err=%b amp=%h upd=%b cnt=%h, want busy=0 err=1 amp=ff upd=0 cnt=01",
                     busy, frame_err, amplitude, cfg_update, err_count);
        end
        idle(1);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got err=%b, want 0", frame_err);
        end
        send_byte(8'h41);
        vectors++;
        if ({gen_enable, cfg_update, amplitude} !== {1'b1, 1'b1, 8'hFF}) begin
            miscompares++;
            $display("FAIL enable_after_abort: got en=%b upd=%b amp=%h, want en=1 upd=1 amp=ff", gen_enable, cfg_update, amplitude);
        end
        send_byte(8'h40);
        vectors++;
        if ({gen_enable, cfg_update} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL disable: got en=%b upd=%b, want en=0 upd=1", gen_enable, cfg_update);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send_byte(8'h9A);
        vectors++;
        if ({frame_err, err_count, cfg_update, busy} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_op: got err=%b cnt=%h upd=%b busy=%b, want err=1 cnt=01 upd=0 busy=0",
                     frame_err, err_count, cfg_update, busy);
        end
        for (int i = 0; i < 253; i++) send_byte(8'h50 + 8'(i % 11) * 8'h10);
        vectors++;
        if (err_count !== 8'hFE) begin
            miscompares++;
            $display("FAIL err_count_254: got cnt=%h, want fe", err_count);
        end
        for (int i = 0; i < 46; i++) send_byte(8'hF0);
        vectors++;
        if ({err_count, frame_err} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL err_saturate: got cnt=%h err=%b, want cnt=ff err=1", err_count, frame_err);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_byte(8'h20);
        send_byte(8'hAB);
        do_reset();
        vectors++;
        if ({busy, phase_inc} !== {1'b0, 16'h0100}) begin
            miscompares++;
            $display("FAIL midframe_reset: got busy=%b inc=%h, want busy=0 inc=0100", busy, phase_inc);
        end
        send_byte(8'hCD);
        vectors++;
        if ({frame_err, phase_inc, cfg_update, busy} !== {1'b1, 16'h0100, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midframe_discard: got err=%b inc=%h upd=%b busy=%b, want err=1 inc=0100 upd=0 busy=0",
                     frame_err, phase_inc, cfg_update, busy);
        end
    endtask

    task automatic test_byte_at_expiry();
        int err_seen;
        err_seen = 0;
        do_reset();
        send_byte(8'h30);
        for (int i = 0; i < T - 1; i++) begin
            idle(1);
            if (frame_err) err_seen++;
        end
        send_byte(8'h40);
        vectors++;
        if ({amplitude, frame_err, cfg_update, busy} !== {8'h40, 1'b0, 1'b1, 1'b0} || err_seen != 0) begin
            miscompares++;
            $display("FAIL byte_at_expiry: got amp=%h err=%b upd=%b busy=%b early_errs=%0d, want amp=40 err=0 upd=1 busy=0 early_errs=0",
                     amplitude, frame_err, cfg_update, busy, err_seen);
        end
        idle(1);
        vectors++;
        if ({frame_err, err_count} !== {1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL byte_at_expiry_after: got err=%b cnt=%h, want err=0 cnt=00", frame_err, err_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Payload bytes that look like opcodes are data
        send_byte(8'h20);
        send_byte(8'h13);
        send_byte(8'h9A);
        vectors++;
        if ({phase_inc, wave_sel, frame_err, cfg_update} !== {16'h139A, 2'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL payload_as_data: got inc=%h ws=%0d err=%b upd=%b, want inc=139a ws=0 err=0 upd=1",
                     phase_inc, wave_sel, frame_err, cfg_update);
        end
        send_byte(8'h31);
        send_byte(8'h5C);
        send_byte(8'h12);
        vectors++;
        if ({amplitude, wave_sel, cfg_update, busy} !== {8'h5C, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL back_to_back: got amp=%h ws=%0d upd=%b busy=%b, want amp=5c ws=2 upd=1 busy=0",
                     amplitude, wave_sel, cfg_update, busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_byte    = 8'h00;
        test_reset();
        test_set_wave();
        test_set_freq();
        test_timeout();
        test_illegal();
        test_reset_midframe();
        test_byte_at_expiry();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
